// File: rtl/sub_32_pipe.sv
// Two-stage pipelined 32-bit subtractor (diff = a - b - bin) with valid/ready on both sides.
// Define SUB32_FLAGS_EN to register {N,Z,C,V} flags; otherwise flags is tied to 4'h0.
module sub_32_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_reg,
  input  logic [31:0] b_reg,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        bout,
  output logic [3:0]  flags
);

  logic        s1_load_s;
  logic        s2_load_s;
  logic [16:0] lo_sub_s;
  logic [16:0] hi_sub_s;
  logic [31:0] full_diff_s;

  logic        s1_valid_q, s1_valid_d;
  logic [15:0] s1_lo_q,    s1_lo_d;
  logic        s1_brw_q,   s1_brw_d;
  logic [15:0] s1_ahi_q,   s1_ahi_d;
  logic [15:0] s1_bhi_q,   s1_bhi_d;
`ifdef SUB32_FLAGS_EN
  logic        s1_as_q,    s1_as_d;
  logic        s1_bs_q,    s1_bs_d;
`endif

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] diff_q,     diff_d;
  logic        bout_q,     bout_d;
  logic [3:0]  flags_q,    flags_d;

  // Handshake: a stage loads when empty or when its occupant leaves this cycle.
  always_comb begin
    s2_load_s = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready  = !s1_valid_q || s2_load_s;
    s1_load_s = in_valid && in_ready;
  end

  // Stage 1: low-half subtract; bit 16 of the 17-bit result is the half borrow.
  always_comb begin
    lo_sub_s = {1'b0, a_reg[15:0]} - {1'b0, b_reg[15:0]} - {16'h0000, bin};
    if (s1_load_s) begin
      s1_lo_d  = lo_sub_s[15:0];
      s1_brw_d = lo_sub_s[16];
      s1_ahi_d = a_reg[31:16];
      s1_bhi_d = b_reg[31:16];
    end else begin
      s1_lo_d  = s1_lo_q;
      s1_brw_d = s1_brw_q;
      s1_ahi_d = s1_ahi_q;
      s1_bhi_d = s1_bhi_q;
    end
`ifdef SUB32_FLAGS_EN
    if (s1_load_s) begin
      s1_as_d = a_reg[31];
      s1_bs_d = b_reg[31];
    end else begin
      s1_as_d = s1_as_q;
      s1_bs_d = s1_bs_q;
    end
`endif
    if (s1_load_s) begin
      s1_valid_d = 1'b1;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2: high-half subtract consuming the registered half borrow.
  always_comb begin
    hi_sub_s    = {1'b0, s1_ahi_q} - {1'b0, s1_bhi_q} - {16'h0000, s1_brw_q};
    full_diff_s = {hi_sub_s[15:0], s1_lo_q};
    if (s2_load_s) begin
      diff_d = full_diff_s;
      bout_d = hi_sub_s[16];
`ifdef SUB32_FLAGS_EN
      flags_d = {full_diff_s[31],
                 (full_diff_s == 32'h0000_0000),
                 hi_sub_s[16],
                 (s1_as_q ^ s1_bs_q) & (full_diff_s[31] ^ s1_as_q)};
`else
      flags_d = 4'h0;
`endif
    end else begin
      diff_d  = diff_q;
      bout_d  = bout_q;
      flags_d = flags_q;
    end
    if (s2_load_s) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline state registers; reset discards any in-flight beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= 16'h0000;
      s1_brw_q   <= 1'b0;
      s1_ahi_q   <= 16'h0000;
      s1_bhi_q   <= 16'h0000;
`ifdef SUB32_FLAGS_EN
      s1_as_q    <= 1'b0;
      s1_bs_q    <= 1'b0;
`endif
      s2_valid_q <= 1'b0;
      diff_q     <= 32'h0000_0000;
      bout_q     <= 1'b0;
      flags_q    <= 4'h0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_brw_q   <= s1_brw_d;
      s1_ahi_q   <= s1_ahi_d;
      s1_bhi_q   <= s1_bhi_d;
`ifdef SUB32_FLAGS_EN
      s1_as_q    <= s1_as_d;
      s1_bs_q    <= s1_bs_d;
`endif
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign flags     = flags_q;

endmodule
